// File: rtl/uart2_rx_pkg.sv
// Shared types and constants for the uart2 receiver.
// UART2_RX_PARITY_EN adds an even-parity bit after the data bits; it must match the uart2_tx build.
package uart2_rx_pkg;

  localparam int unsigned DataWidth         = 8;
  localparam int unsigned DefaultOversample = 16;

`ifdef UART2_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_e;

  function automatic logic even_parity_ok(input logic [DataWidth-1:0] data, input logic par);
    return ~(^{data, par});
  endfunction
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} rx_state_e;
`endif

endpackage

// File: rtl/uart2_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// ResetVal selects the value both flops take during reset.
module uart2_rx_sync #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart2_rx.sv
// Oversampling serial receiver, 8 data bits LSB first, one stop bit, idle-high line.
// Define UART2_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart2_rx
  import uart2_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DefaultOversample
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  output logic [DataWidth-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_overrun,
  output logic                 rx_frame_err
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  // IDLE already consumed one low cycle, so mid-start is reached OVERSAMPLE/2-1 edges later.
  localparam logic [CntW-1:0] StartMid = CntW'(OVERSAMPLE / 2 - 2);
  localparam logic [CntW-1:0] BitEnd   = CntW'(OVERSAMPLE - 1);

  logic rxs;

  uart2_rx_sync #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_in),
    .q    (rxs)
  );

  rx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DataWidth-1:0] shift_q;
  logic                 armed_q;
  logic [DataWidth-1:0] rx_data_q;
  logic                 rx_empty_q;
  logic                 rx_overrun_q;
  logic                 rx_frame_err_q;
  logic                 frame_good;

`ifdef UART2_RX_PARITY_EN
  logic par_ok_q;
  assign frame_good = rxs & par_ok_q;
`else
  assign frame_good = rxs;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      armed_q        <= 1'b1;
      rx_data_q      <= '0;
      rx_empty_q     <= 1'b1;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef UART2_RX_PARITY_EN
      par_ok_q       <= 1'b0;
`endif
    end else begin
      if (uld_rx_data) begin
        rx_empty_q     <= 1'b1;
        rx_overrun_q   <= 1'b0;
        rx_frame_err_q <= 1'b0;
      end
      if (!rx_enable) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        // A line that is low on re-enable is mid-frame; wait for it to go high.
        armed_q <= rxs;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rxs) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= StStart;
              cnt_q   <= '0;
            end
          end
          StStart: begin
            if (cnt_q == StartMid) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= rxs ? StIdle : StData;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StData: begin
            if (cnt_q == BitEnd) begin
              cnt_q     <= '0;
              shift_q   <= {rxs, shift_q[DataWidth-1:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
`ifdef UART2_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
`ifdef UART2_RX_PARITY_EN
          StParity: begin
            if (cnt_q == BitEnd) begin
              cnt_q    <= '0;
              par_ok_q <= even_parity_ok(shift_q, rxs);
              state_q  <= StStop;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
`endif
          StStop: begin
            if (cnt_q == BitEnd) begin
              cnt_q   <= '0;
              state_q <= StIdle;
              if (frame_good) begin
                if (rx_empty_q || uld_rx_data) begin
                  rx_data_q  <= shift_q;
                  rx_empty_q <= 1'b0;
                end else begin
                  rx_overrun_q <= 1'b1;
                end
              end else begin
                rx_frame_err_q <= 1'b1;
                // A held-low line (break) must go high before another start is taken.
                armed_q        <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_empty     = rx_empty_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart2_rx.sv
// Self-checking bench for uart2_rx: expected bytes are queued as frames are sent and
// popped when the receiver reports a byte.
module tb_uart2_rx;

  localparam int unsigned OS = 16;
`ifdef UART2_RX_PARITY_EN
  localparam int unsigned Latency = 2 + OS / 2 + 10 * OS;
`else
  localparam int unsigned Latency = 2 + OS / 2 + 9 * OS;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_enable;
  logic       rx_in;
  logic       uld_rx_data;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_overrun;
  logic       rx_frame_err;

  int          checks = 0;
  int          passed = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  held = 8'h00;
`ifdef UART2_RX_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  uart2_rx #(
    .OVERSAMPLE(OS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_enable   (rx_enable),
    .rx_in       (rx_in),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_in = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (OS) @(negedge clk);
    end
`ifdef UART2_RX_PARITY_EN
    rx_in = (^d) ^ par_flip;
    repeat (OS) @(negedge clk);
`endif
    rx_in = stop;
    repeat (OS) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic wait_loaded(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!rx_empty) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else passed++;
    checks++; if (rx_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", rx_empty); else passed++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", rx_overrun); else passed++;
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", rx_frame_err); else passed++;
  endtask

  task automatic test_basic();
    int unsigned t0;
    int unsigned lat;
    bit          ok;
    logic [7:0]  exp;
    t0 = cyc;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_loaded(ok);
        lat = cyc - t0;
      end
    join
    exp = exp_q.pop_front();
    held = exp;
    checks++; if (!ok) $display("FAIL basic_load: got timeout want byte"); else passed++;
    checks++; if (lat !== Latency) $display("FAIL basic_latency: got %0d want %0d", lat, Latency); else passed++;
    checks++; if (rx_data !== exp) $display("FAIL basic_data: got %h want %h", rx_data, exp); else passed++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL basic_overrun: got %b want 0", rx_overrun); else passed++;
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL basic_ferr: got %b want 0", rx_frame_err); else passed++;
    unload();
    checks++; if (rx_empty !== 1'b1) $display("FAIL basic_unload: got %b want 1", rx_empty); else passed++;
    checks++; if (rx_data !== held) $display("FAIL basic_keep: got %h want %h", rx_data, held); else passed++;
  endtask

  task automatic test_glitch();
    bit         ok;
    logic [7:0] exp;
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * OS) @(negedge clk);
    checks++; if (rx_empty !== 1'b1) $display("FAIL glitch_empty: got %b want 1", rx_empty); else passed++;
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL glitch_ferr: got %b want 0", rx_frame_err); else passed++;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_loaded(ok);
    exp = exp_q.pop_front();
    held = exp;
    checks++; if (!ok || rx_data !== exp) $display("FAIL glitch_data: got %h want %h", rx_data, exp); else passed++;
    unload();
  endtask

  task automatic test_back_to_back();
    fork
      begin
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          send_frame(d, 1'b1);
        end
      end
      begin
        bit         ok;
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
          wait_loaded(ok);
          exp = exp_q.pop_front();
          held = exp;
          checks++; if (!ok || rx_data !== exp) $display("FAIL b2b_data%0d: got %h want %h", i, rx_data, exp); else passed++;
          unload();
        end
      end
    join
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    exp = exp_q.pop_front();
    held = exp;
    checks++; if (rx_data !== exp) $display("FAIL ovr_data: got %h want %h", rx_data, exp); else passed++;
    checks++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", rx_overrun); else passed++;
    checks++; if (rx_empty !== 1'b0) $display("FAIL ovr_empty: got %b want 0", rx_empty); else passed++;
    unload();
    checks++; if (rx_empty !== 1'b1) $display("FAIL ovr_uld_empty: got %b want 1", rx_empty); else passed++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL ovr_uld_flag: got %b want 0", rx_overrun); else passed++;
  endtask

  task automatic test_uld_same_cycle();
    bit          ok;
    int unsigned t0;
    logic [7:0]  exp;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_loaded(ok);
    exp = exp_q.pop_front();
    checks++; if (!ok || rx_data !== exp) $display("FAIL same_first: got %h want %h", rx_data, exp); else passed++;
    t0 = cyc;
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        // Unload strobe lands on the same edge that completes the next frame.
        while (cyc != t0 + Latency - 1) @(negedge clk);
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
      end
    join
    exp = exp_q.pop_front();
    held = exp;
    checks++; if (rx_data !== exp) $display("FAIL same_data: got %h want %h", rx_data, exp); else passed++;
    checks++; if (rx_empty !== 1'b0) $display("FAIL same_empty: got %b want 0", rx_empty); else passed++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL same_overrun: got %b want 0", rx_overrun); else passed++;
    unload();
  endtask

  task automatic test_frame_err();
    bit         ok;
    logic [7:0] exp;
    send_frame(8'h81, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_flag: got %b want 1", rx_frame_err); else passed++;
    checks++; if (rx_empty !== 1'b1) $display("FAIL ferr_empty: got %b want 1", rx_empty); else passed++;
    checks++; if (rx_data !== held) $display("FAIL ferr_data: got %h want %h", rx_data, held); else passed++;
    unload();
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL ferr_clear: got %b want 0", rx_frame_err); else passed++;
    // Break: one error, then no re-arm while the line stays low.
    rx_in = 1'b0;
    repeat (12 * OS) @(negedge clk);
    checks++; if (rx_frame_err !== 1'b1) $display("FAIL break_flag: got %b want 1", rx_frame_err); else passed++;
    unload();
    repeat (15 * OS) @(negedge clk);
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL break_rearm: got %b want 0", rx_frame_err); else passed++;
    checks++; if (rx_empty !== 1'b1) $display("FAIL break_empty: got %b want 1", rx_empty); else passed++;
    rx_in = 1'b1;
    repeat (OS) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_loaded(ok);
    exp = exp_q.pop_front();
    held = exp;
    checks++; if (!ok || rx_data !== exp) $display("FAIL break_after: got %h want %h", rx_data, exp); else passed++;
    unload();
  endtask

  task automatic test_disable();
    bit         ok;
    logic [7:0] exp;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * OS + OS / 2) @(negedge clk);
        rx_enable = 1'b0;
      end
    join
    rx_enable = 1'b1;
    repeat (2 * OS) @(negedge clk);
    checks++; if (rx_empty !== 1'b1) $display("FAIL dis_empty: got %b want 1", rx_empty); else passed++;
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL dis_ferr: got %b want 0", rx_frame_err); else passed++;
    checks++; if (rx_data !== held) $display("FAIL dis_data: got %h want %h", rx_data, held); else passed++;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_loaded(ok);
    exp = exp_q.pop_front();
    held = exp;
    checks++; if (!ok || rx_data !== exp) $display("FAIL dis_after: got %h want %h", rx_data, exp); else passed++;
    unload();
  endtask

`ifdef UART2_RX_PARITY_EN
  task automatic test_parity();
    bit         ok;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'(i * 37 + 3));
      send_frame(8'(i * 37 + 3), 1'b1);
      wait_loaded(ok);
      exp = exp_q.pop_front();
      held = exp;
      checks++; if (!ok || rx_data !== exp) $display("FAIL par_data%0d: got %h want %h", i, rx_data, exp); else passed++;
      unload();
    end
    par_flip = 1'b1;
    send_frame(8'h96, 1'b1);
    par_flip = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rx_frame_err !== 1'b1) $display("FAIL par_err: got %b want 1", rx_frame_err); else passed++;
    checks++; if (rx_empty !== 1'b1) $display("FAIL par_empty: got %b want 1", rx_empty); else passed++;
    checks++; if (rx_data !== held) $display("FAIL par_keep: got %h want %h", rx_data, held); else passed++;
    unload();
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    send_frame(8'hC3, 1'b1);
    wait_loaded(ok);
    checks++; if (!ok || rx_data !== 8'hC3) $display("FAIL rmid_pre: got %h want c3", rx_data); else passed++;
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (5 * OS) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
      end
    join
    repeat (OS) @(negedge clk);
    reset = 1'b1;
    repeat (2 * OS) @(negedge clk);
    checks++; if (rx_empty !== 1'b1) $display("FAIL rmid_after: got %b want 1", rx_empty); else passed++;
  endtask

  initial begin
    reset       = 1'b0;
    rx_enable   = 1'b1;
    rx_in       = 1'b1;
    uld_rx_data = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_overrun();
    test_uld_same_cycle();
    test_frame_err();
    test_disable();
`ifdef UART2_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
